// File: rtl/if_id_skid_pkg.sv
// Shared definitions for the IF/ID pipeline register: the canonical NOP encoding
// and the main-entry update operations.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package if_id_skid_pkg;

  localparam int unsigned DEF_INST_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;

  // What the main entry does on the next rising edge.
  typedef enum logic [1:0] {
    MAIN_KEEP      = 2'd0,
    MAIN_LOAD_IN   = 2'd1,
    MAIN_LOAD_SKID = 2'd2,
    MAIN_CLEAR     = 2'd3
  } main_op_e;

endpackage

// File: rtl/dff_en_set.sv
// Enabled storage register with asynchronous active-low reset to a
// parametrised value; used for every stored field of the IF/ID stage.
module dff_en_set #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage with async reset and load enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with an optional second (skid) entry so that in_ready
// can be registered; flush and decode hold are handled in the same stage.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int unsigned       INST_W  = DEF_INST_W,
  parameter int unsigned       ADDR_W  = DEF_ADDR_W,
  parameter logic [INST_W-1:0] NOP_VAL = INST_W'(`INST_NOP),
  parameter bit                SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o
);

  logic              main_valid, main_valid_d, main_load;
  logic [INST_W-1:0] main_inst, main_inst_d;
  logic [ADDR_W-1:0] main_addr, main_addr_d;
  logic              skid_valid, skid_valid_d, skid_load;
  logic              skid_valid_nxt, skid_en;
  logic [INST_W-1:0] skid_inst;
  logic [ADDR_W-1:0] skid_addr;
  logic              in_ready_q;
  logic              in_fire, out_fire;
  main_op_e          main_op;

  assign out_fire = main_valid & out_ready & ~hold_i;
  assign in_ready = SKID_EN ? in_ready_q : (~main_valid | out_fire);
  assign in_fire  = in_valid & in_ready;

  // Decide the main-entry operation and the skid-entry update for this cycle.
  always_comb begin
    main_op      = MAIN_KEEP;
    skid_valid_d = skid_valid;
    skid_load    = 1'b0;
    if (flush_i) begin
      main_op      = MAIN_CLEAR;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      if (skid_valid) begin
        main_op      = MAIN_LOAD_SKID;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_op = MAIN_LOAD_IN;
      end else begin
        main_op = MAIN_CLEAR;
      end
    end else if (in_fire) begin
      // Without skid the stage is never ready while main is full and stalled.
      if (!main_valid) begin
        main_op = MAIN_LOAD_IN;
      end else begin
        skid_load    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else begin
      main_op = MAIN_KEEP;
    end
  end

  // Translate the main-entry operation into register inputs.
  always_comb begin
    main_valid_d = main_valid;
    main_load    = 1'b0;
    main_inst_d  = inst_i;
    main_addr_d  = inst_addr_i;
    case (main_op)
      MAIN_KEEP: begin
        main_valid_d = main_valid;
      end
      MAIN_LOAD_IN: begin
        main_valid_d = 1'b1;
        main_load    = 1'b1;
      end
      MAIN_LOAD_SKID: begin
        main_valid_d = 1'b1;
        main_load    = 1'b1;
        main_inst_d  = skid_inst;
        main_addr_d  = skid_addr;
      end
      MAIN_CLEAR: begin
        main_valid_d = 1'b0;
      end
      default: begin
        main_valid_d = main_valid;
      end
    endcase
  end

  assign skid_valid_nxt = skid_valid_d & SKID_EN;
  assign skid_en        = skid_load & SKID_EN;

  dff_en_set #(.W(1), .RST_VAL(1'b0)) u_main_valid (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(main_valid_d), .q(main_valid));
  dff_en_set #(.W(INST_W), .RST_VAL('0)) u_main_inst (
    .clk(clk), .rst_n(rst_n), .en(main_load), .d(main_inst_d), .q(main_inst));
  dff_en_set #(.W(ADDR_W), .RST_VAL('0)) u_main_addr (
    .clk(clk), .rst_n(rst_n), .en(main_load), .d(main_addr_d), .q(main_addr));

  dff_en_set #(.W(1), .RST_VAL(1'b0)) u_skid_valid (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(skid_valid_nxt), .q(skid_valid));
  dff_en_set #(.W(INST_W), .RST_VAL('0)) u_skid_inst (
    .clk(clk), .rst_n(rst_n), .en(skid_en), .d(inst_i), .q(skid_inst));
  dff_en_set #(.W(ADDR_W), .RST_VAL('0)) u_skid_addr (
    .clk(clk), .rst_n(rst_n), .en(skid_en), .d(inst_addr_i), .q(skid_addr));

  // Registered ready: open exactly when the skid entry will be empty.
  dff_en_set #(.W(1), .RST_VAL(1'b1)) u_in_ready (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(~skid_valid_nxt), .q(in_ready_q));

  assign out_valid   = main_valid;
  assign inst_o      = main_valid ? main_inst : NOP_VAL;
  assign inst_addr_o = main_valid ? main_addr : '0;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: a two-entry instance and a single-register 16-bit
// instance, both checked every cycle against queue-based reference models.
module tb_if_id_skid;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Two-entry instance (defaults)
  logic        v1, ir1, fl1, hd1, ov1, or1;
  logic [31:0] inst1, addr1, io1, ao1;
  // Single-register instance, 16-bit instructions
  logic        v0, ir0, fl0, hd0, ov0, or0;
  logic [15:0] inst0, io0;
  logic [31:0] addr0, ao0;

  if_id_skid dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .inst_i(inst1),
    .inst_addr_i(addr1), .flush_i(fl1), .hold_i(hd1), .out_valid(ov1),
    .out_ready(or1), .inst_o(io1), .inst_addr_o(ao1));

  if_id_skid #(.INST_W(16), .ADDR_W(32), .NOP_VAL(16'h0013), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .inst_i(inst0),
    .inst_addr_i(addr0), .flush_i(fl0), .hold_i(hd0), .out_valid(ov0),
    .out_ready(or0), .inst_o(io0), .inst_addr_o(ao0));

  int checks = 0;
  int errors = 0;
  logic [63:0] q1[$];
  logic [63:0] q0[$];
  bit acc1, acc0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a FIFO of capacity 2 (skid) or 1 (single register).
  function automatic bit m1_ready();
    return q1.size() < 2;
  endfunction

  function automatic bit m0_ready();
    return (q0.size() == 0) || (or0 && !hd0);
  endfunction

  task automatic model_update();
    bit f1, o1, f0, o0;
    if (!rst_n) begin
      q1.delete(); q0.delete(); acc1 = 1'b0; acc0 = 1'b0;
      return;
    end
    f1 = v1 && m1_ready();
    o1 = (q1.size() != 0) && or1 && !hd1;
    f0 = v0 && m0_ready();
    o0 = (q0.size() != 0) && or0 && !hd0;
    acc1 = f1 && !fl1;
    acc0 = f0 && !fl0;
    if (fl1) q1.delete();
    else begin
      if (o1) void'(q1.pop_front());
      if (f1) q1.push_back({addr1, inst1});
    end
    if (fl0) q0.delete();
    else begin
      if (o0) void'(q0.pop_front());
      if (f0) q0.push_back({16'h0, addr0, inst0});
    end
  endtask

  task automatic check_all();
    logic [63:0] h1, h0;
    h1 = (q1.size() != 0) ? q1[0] : 64'h0000_0000_0000_0013;
    h0 = (q0.size() != 0) ? q0[0] : 64'h0000_0000_0000_0013;
    chk("s_in_ready",  {63'h0, ir1}, {63'h0, m1_ready()});
    chk("s_out_valid", {63'h0, ov1}, {63'h0, q1.size() != 0});
    chk("s_inst",      {32'h0, io1}, {32'h0, h1[31:0]});
    chk("s_addr",      {32'h0, ao1}, {32'h0, h1[63:32]});
    chk("r_in_ready",  {63'h0, ir0}, {63'h0, m0_ready()});
    chk("r_out_valid", {63'h0, ov0}, {63'h0, q0.size() != 0});
    chk("r_inst",      {48'h0, io0}, {48'h0, h0[15:0]});
    chk("r_addr",      {32'h0, ao0}, {32'h0, h0[47:16]});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    v1 = 1'b0; fl1 = 1'b0; hd1 = 1'b0; or1 = 1'b1; inst1 = 32'h0; addr1 = 32'h0;
    v0 = 1'b0; fl0 = 1'b0; hd0 = 1'b0; or0 = 1'b1; inst0 = 16'h0; addr0 = 32'h0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'h0, ov1}, 64'h0);
    chk("rst_inst",      {32'h0, io1}, 64'h13);
    chk("rst_addr",      {32'h0, ao1}, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_skid", {63'h0, ir1}, 64'h1);
    chk("rel_in_ready_reg",  {63'h0, ir0}, 64'h1);
    @(negedge clk);

    // Streaming, back-to-back
    or1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v1 = 1'b1; inst1 = 32'hA0 + 32'(i); addr1 = 32'h100 + 32'(4 * i);
      cycle();
      chk("stream_inst", {32'h0, io1}, {32'h0, 32'hA0 + 32'(i)});
      chk("stream_ready", {63'h0, ir1}, 64'h1);
    end
    v1 = 1'b0;
    repeat (2) cycle();

    // Backpressure: two accepted, third refused until drain starts
    or1 = 1'b0; v1 = 1'b1; inst1 = 32'hC1; addr1 = 32'h200;
    cycle();
    inst1 = 32'hC2; addr1 = 32'h204;
    cycle();
    chk("bp_ready_low", {63'h0, ir1}, 64'h0);
    inst1 = 32'hC3; addr1 = 32'h208;
    cycle();
    chk("bp_c3_refused", {63'h0, acc1}, 64'h0);
    chk("bp_head", {32'h0, io1}, 64'hC1);
    or1 = 1'b1;
    for (int n = 0; n < 8 && !acc1; n++) cycle();
    chk("bp_c3_accepted", {63'h0, acc1}, 64'h1);
    v1 = 1'b0;
    repeat (3) cycle();

    // Flush with a full stage and a simultaneous beat
    or1 = 1'b0; v1 = 1'b1; inst1 = 32'hD0; addr1 = 32'h300;
    cycle();
    inst1 = 32'hD1; addr1 = 32'h304;
    cycle();
    fl1 = 1'b1; inst1 = 32'hBB; addr1 = 32'h308;
    cycle();
    fl1 = 1'b0; v1 = 1'b0; or1 = 1'b1;
    chk("fl_out_valid", {63'h0, ov1}, 64'h0);
    chk("fl_inst_nop",  {32'h0, io1}, 64'h13);
    chk("fl_in_ready",  {63'h0, ir1}, 64'h1);
    repeat (2) cycle();

    // Hold freezes the output entry
    v1 = 1'b1; inst1 = 32'hE0; addr1 = 32'h400;
    cycle();
    v1 = 1'b0; hd1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_inst", {32'h0, io1}, 64'hE0);
    end
    hd1 = 1'b0;
    cycle();
    chk("hold_drained", {63'h0, ov1}, 64'h0);

    // Reset in the middle of a transfer
    or1 = 1'b0; v1 = 1'b1; inst1 = 32'hF0; addr1 = 32'h500;
    cycle();
    inst1 = 32'hF1; addr1 = 32'h504;
    cycle();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'h0, ov1}, 64'h0);
    chk("mid_rst_inst",      {32'h0, io1}, 64'h13);
    chk("mid_rst_addr",      {32'h0, ao1}, 64'h0);
    q1.delete(); q0.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", {63'h0, ir1}, 64'h1);
    @(negedge clk);
    check_all();

    // Single-register instance: out_ready toggling under continuous valid
    v0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      or0 = i[0];
      if (i == 0 || acc0) begin
        inst0 = 16'h5000 + 16'(i); addr0 = 32'h600 + 32'(4 * i);
      end
      cycle();
    end
    v0 = 1'b0; or0 = 1'b1;
    repeat (2) cycle();

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      v1 = ($urandom_range(0, 3) != 0); or1 = $urandom_range(0, 1) == 1;
      hd1 = ($urandom_range(0, 7) == 0); fl1 = ($urandom_range(0, 31) == 0);
      inst1 = $urandom; addr1 = $urandom;
      v0 = ($urandom_range(0, 3) != 0); or0 = $urandom_range(0, 1) == 1;
      hd0 = ($urandom_range(0, 7) == 0); fl0 = ($urandom_range(0, 31) == 0);
      inst0 = 16'($urandom); addr0 = $urandom;
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
